// File: rtl/psram_apb_arbiter.sv
// psram_apb_arbiter: round-robin 2:1 APB arbiter in front of the PSRAM wrapper.
// Define PSRAM_ARB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT cycles.
module psram_apb_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in0_paddr,
  input  logic        in0_psel,
  input  logic        in0_penable,
  input  logic [2:0]  in0_pprot,
  input  logic        in0_pwrite,
  input  logic [31:0] in0_pwdata,
  input  logic [3:0]  in0_pstrb,
  output logic        in0_pready,
  output logic [31:0] in0_prdata,
  output logic        in0_pslverr,
  input  logic [31:0] in1_paddr,
  input  logic        in1_psel,
  input  logic        in1_penable,
  input  logic [2:0]  in1_pprot,
  input  logic        in1_pwrite,
  input  logic [31:0] in1_pwdata,
  input  logic [3:0]  in1_pstrb,
  output logic        in1_pready,
  output logic [31:0] in1_prdata,
  output logic        in1_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic [31:0] paddr_q, paddr_d;
  logic [2:0]  pprot_q, pprot_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        done, tmo;
  logic        unused_penable;

  assign unused_penable = in0_penable ^ in1_penable;

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tmo = (state_q == ACCESS) && !out_pready &&
               (cnt_q == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (out_pready || tmo);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
`ifdef PSRAM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in0_psel || in1_psel) begin
          // Tie goes to whoever was not served last.
          grant_d  = (in0_psel && in1_psel) ? ~last_q : in1_psel;
          paddr_d  = grant_d ? in1_paddr  : in0_paddr;
          pprot_d  = grant_d ? in1_pprot  : in0_pprot;
          pwrite_d = grant_d ? in1_pwrite : in0_pwrite;
          pwdata_d = grant_d ? in1_pwdata : in0_pwdata;
          pstrb_d  = grant_d ? in1_pstrb  : in0_pstrb;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef PSRAM_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (done) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          last_d    = grant_q;
          state_d   = IDLE;
        end
`ifdef PSRAM_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
`ifdef PSRAM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
`ifdef PSRAM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign out_psel    = psel_q;
  assign out_penable = penable_q;
  assign out_paddr   = paddr_q;
  assign out_pprot   = pprot_q;
  assign out_pwrite  = pwrite_q;
  assign out_pwdata  = pwdata_q;
  assign out_pstrb   = pstrb_q;

  // Timeout completions report an error with zeroed read data.
  assign in0_pready  = done && !grant_q;
  assign in0_prdata  = (done && !grant_q && !tmo) ? out_prdata : '0;
  assign in0_pslverr = done && !grant_q && (tmo || out_pslverr);
  assign in1_pready  = done && grant_q;
  assign in1_prdata  = (done && grant_q && !tmo) ? out_prdata : '0;
  assign in1_pslverr = done && grant_q && (tmo || out_pslverr);

endmodule

// File: tb/tb_psram_apb_arbiter.sv
// Bench for psram_apb_arbiter: transaction-level model compared every cycle
// plus directed scenarios with literal expectations.
module tb_psram_apb_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in0_paddr, in1_paddr, in0_pwdata, in1_pwdata;
  logic        in0_psel, in1_psel, in0_penable, in1_penable;
  logic [2:0]  in0_pprot, in1_pprot;
  logic        in0_pwrite, in1_pwrite;
  logic [3:0]  in0_pstrb, in1_pstrb;
  logic        in0_pready, in1_pready, in0_pslverr, in1_pslverr;
  logic [31:0] in0_prdata, in1_prdata;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit run = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  psram_apb_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in0_paddr(in0_paddr), .in0_psel(in0_psel), .in0_penable(in0_penable),
    .in0_pprot(in0_pprot), .in0_pwrite(in0_pwrite), .in0_pwdata(in0_pwdata),
    .in0_pstrb(in0_pstrb), .in0_pready(in0_pready), .in0_prdata(in0_prdata),
    .in0_pslverr(in0_pslverr),
    .in1_paddr(in1_paddr), .in1_psel(in1_psel), .in1_penable(in1_penable),
    .in1_pprot(in1_pprot), .in1_pwrite(in1_pwrite), .in1_pwdata(in1_pwdata),
    .in1_pstrb(in1_pstrb), .in1_pready(in1_pready), .in1_prdata(in1_prdata),
    .in1_pslverr(in1_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  // Simple slave: ready after slave_wait ACCESS cycles, or never.
  int          slave_wait = 0;
  bit          slave_never = 0;
  logic [31:0] slave_rdata = '0;
  logic        slave_err = 1'b0;
  int          acnt = 0;

  always @(posedge clk)
    if (!out_penable || out_pready) acnt <= 0;
    else acnt <= acnt + 1;

  assign out_pready  = out_penable && !slave_never && (acnt == slave_wait);
  assign out_prdata  = slave_rdata;
  assign out_pslverr = slave_err;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  // Model: one transfer = grant edge, then age counts cycles since grant.
  bit          m_busy, m_g, m_last;
  int          m_age;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_prot;
  logic        m_write;
  logic [3:0]  m_strb;

  function automatic bit m_tmo();
`ifdef PSRAM_ARB_TIMEOUT_EN
    return m_busy && m_age >= 2 && out_pready !== 1'b1 &&
           (m_age - 2 == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_done();
    return m_busy && m_age >= 2 && (out_pready === 1'b1 || m_tmo());
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_last = 1; m_age = 0; m_g = 0;
      m_addr = '0; m_wdata = '0; m_prot = '0; m_write = 0; m_strb = '0;
    end else if (!m_busy) begin
      if (in0_psel || in1_psel) begin
        if (in0_psel && in1_psel) m_g = (m_last == 0);
        else m_g = in1_psel;
        m_addr  = m_g ? in1_paddr  : in0_paddr;
        m_wdata = m_g ? in1_pwdata : in0_pwdata;
        m_prot  = m_g ? in1_pprot  : in0_pprot;
        m_write = m_g ? in1_pwrite : in0_pwrite;
        m_strb  = m_g ? in1_pstrb  : in0_pstrb;
        m_busy = 1; m_age = 1;
      end
    end else if (m_done()) begin
      m_busy = 0; m_last = m_g;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) if (run) begin
    bit d, t, d0, d1;
    d = m_done(); t = m_tmo();
    d0 = d && !m_g; d1 = d && m_g;
    chk("out_psel", out_psel, m_busy);
    chk("out_penable", out_penable, m_busy && m_age >= 2);
    chk("out_paddr", out_paddr, m_addr);
    chk("out_pwdata", out_pwdata, m_wdata);
    chk("out_pprot", out_pprot, m_prot);
    chk("out_pwrite", out_pwrite, m_write);
    chk("out_pstrb", out_pstrb, m_strb);
    chk("in0_pready", in0_pready, d0);
    chk("in0_prdata", in0_prdata, (d0 && !t) ? slave_rdata : 0);
    chk("in0_pslverr", in0_pslverr, d0 && (t || slave_err));
    chk("in1_pready", in1_pready, d1);
    chk("in1_prdata", in1_prdata, (d1 && !t) ? slave_rdata : 0);
    chk("in1_pslverr", in1_pslverr, d1 && (t || slave_err));
  end

  task automatic wait_rdy(output int who, output int at);
    who = -1; at = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in0_pready || in1_pready) begin
        who = in1_pready ? 1 : 0;
        at = cyc;
        break;
      end
    end
    if (who < 0) begin
      checks++; errors++;
      $display("FAIL wait_rdy no pready within 40 cycles");
    end
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    int who, at, prev, start, pulses, pk;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    reset = 1'b1;
    in0_paddr = '0; in0_psel = 0; in0_penable = 0; in0_pprot = '0;
    in0_pwrite = 0; in0_pwdata = '0; in0_pstrb = '0;
    in1_paddr = '0; in1_psel = 0; in1_penable = 0; in1_pprot = '0;
    in1_pwrite = 0; in1_pwdata = '0; in1_pstrb = '0;
    repeat (2) @(negedge clk);
    chk("rst_psel", out_psel, 0);
    chk("rst_penable", out_penable, 0);
    chk("rst_paddr", out_paddr, 0);
    chk("rst_in0_pready", in0_pready, 0);
    run = 1;
    edge1(); reset = 0;
    edge1();

    // in0 read, zero wait states
    slave_rdata = 32'h12345678;
    in0_paddr = 32'h80000010; in0_pwrite = 0; in0_pprot = 3'b010;
    in0_psel = 1;
    @(negedge clk);
    chk("t1_c0_psel", out_psel, 0);
    @(negedge clk);
    chk("t1_c1_psel", out_psel, 1);
    chk("t1_c1_pen", out_penable, 0);
    @(negedge clk);
    chk("t1_c2_pen", out_penable, 1);
    chk("t1_c2_rdy", in0_pready, 1);
    chk("t1_c2_rdata", in0_prdata, 32'h12345678);
    chk("t1_in1_rdy", in1_pready, 0);
    chk("t1_in1_rdata", in1_prdata, 0);
    edge1(); in0_psel = 0;
    @(negedge clk);
    chk("t1_bubble", out_psel, 0);
    edge1();

    // in1 write; master drops psel after grant
    in1_paddr = 32'h80000004; in1_pwrite = 1;
    in1_pwdata = 32'hA5A5A5A5; in1_pstrb = 4'b0110; in1_psel = 1;
    @(negedge clk);
    edge1(); in1_psel = 0; in1_pwdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_c1_pwrite", out_pwrite, 1);
    chk("t2_c1_pstrb", out_pstrb, 4'b0110);
    chk("t2_c1_pwdata", out_pwdata, 32'hA5A5A5A5);
    @(negedge clk);
    chk("t2_c2_pwdata", out_pwdata, 32'hA5A5A5A5);
    chk("t2_c2_paddr", out_paddr, 32'h80000004);
    chk("t2_c2_rdy1", in1_pready, 1);
    chk("t2_c2_rdy0", in0_pready, 0);
    edge1(); in1_pwrite = 0;

    // fairness from reset, both held
    reset = 1; edge1(); reset = 0;
    in0_paddr = 32'h80000100; in1_paddr = 32'h80000200;
    in0_psel = 1; in1_psel = 1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_rdy(who, at);
      chk("fair_grant", who, exp_order[i]);
      if (i > 0) chk("fair_gap", at - prev, 3);
      prev = at;
    end
    edge1(); in0_psel = 0; in1_psel = 0;
    edge1();

    // 5 wait states with error
    slave_wait = 5; slave_err = 1; slave_rdata = 32'hCAFEF00D;
    in0_psel = 1; pulses = 0; pk = -1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (in0_pready) begin
        pulses++; pk = k;
        chk("ws_pslverr", in0_pslverr, 1);
        edge1(); in0_psel = 0;
      end
    end
    chk("ws_pulses", pulses, 1);
    chk("ws_cycle", pk, 7);
    slave_wait = 0; slave_err = 0;
    edge1();

`ifdef PSRAM_ARB_TIMEOUT_EN
    // slave never ready: timeout completion then normal service
    slave_never = 1; slave_rdata = 32'h11112222;
    start = cyc; in0_psel = 1;
    wait_rdy(who, at);
    chk("to_who", who, 0);
    chk("to_cycle", at - start, 2 + TO - 1);
    chk("to_pslverr", in0_pslverr, 1);
    chk("to_prdata", in0_prdata, 0);
    edge1(); in0_psel = 0; slave_never = 0;
    in1_psel = 1;
    wait_rdy(who, at);
    chk("to_next_who", who, 1);
    chk("to_next_rdata", in1_prdata, 32'h11112222);
    chk("to_next_err", in1_pslverr, 0);
    edge1(); in1_psel = 0;
    edge1();
`endif

    // reset during ACCESS
    slave_never = 1; in0_psel = 1;
    repeat (4) @(negedge clk);
    chk("rs_pen_before", out_penable, 1);
    #1 reset = 1;
    #1;
    chk("rs_async_psel", out_psel, 0);
    chk("rs_async_pen", out_penable, 0);
    chk("rs_no_rdy", in0_pready, 0);
    in0_psel = 0; slave_never = 0;
    @(negedge clk); #1 reset = 0;
    edge1(); in0_psel = 1; in1_psel = 1;
    wait_rdy(who, at);
    chk("rs_first_who", who, 0);
    edge1(); in0_psel = 0; in1_psel = 0;
    repeat (3) edge1();
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psram_apb_arbiter.md
Name: psram_apb_arbiter

Overview:
Two-master, one-slave APB arbiter that shares the PSRAM APB port between a CPU-side requester (in0) and a DMA-side requester (in1). It sits directly upstream of the PSRAM APB wrapper. Each granted request is latched and replayed downstream as a clean SETUP/ACCESS pair. Arbitration is round-robin, one transfer per grant.

Parameters:
TIMEOUT, 1024, ACCESS-phase cycle limit; used only when PSRAM_ARB_TIMEOUT_EN is defined. Must be at least 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
inN_paddr  input  32  master N address (N = 0, 1 for all inN_* ports)
inN_psel  input  1  master N select / request
inN_penable  input  1  master N enable; accepted but not used for arbitration
inN_pprot  input  3  master N protection
inN_pwrite  input  1  master N write
inN_pwdata  input  32  master N write data
inN_pstrb  input  4  master N byte strobes
inN_pready  output  1  completion pulse to master N
inN_prdata  output  32  read data to master N
inN_pslverr  output  1  error to master N
out_paddr/out_pprot/out_pwrite/out_pwdata/out_pstrb  output  32/3/1/32/4  latched request, registered
out_psel  output  1  downstream select, registered
out_penable  output  1  downstream enable, registered
out_pready  input  1  downstream ready
out_prdata  input  32  downstream read data
out_pslverr  input  1  downstream error

Behaviour:
- FSM states: IDLE, SETUP, ACCESS. Reset (asynchronous) puts the FSM in IDLE and sets:
  - all out_* registers to 0
  - last_grant = 1, so in0 wins the first tie
  - TIMEOUT counter (when compiled in) to 0
- IDLE: out_psel = 0, out_penable = 0.
  - If only one inN_psel is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - On the grant edge, latch grant and that master's paddr, pprot, pwrite, pwdata and pstrb into the out_* registers, then go to SETUP.
- SETUP: out_psel = 1, out_penable = 0. Unconditionally go to ACCESS next cycle.
- ACCESS: out_psel = 1, out_penable = 1.
  - While out_pready = 0, stay in ACCESS.
  - On out_pready = 1, in the same cycle (combinational):
    - in[grant]_pready = 1
    - in[grant]_prdata = out_prdata
    - in[grant]_pslverr = out_pslverr
  - Then set last_grant = grant, clear out_psel/out_penable, and go to IDLE.
- Non-granted master, and any master outside its completion cycle: pready = 0, prdata = 0, pslverr = 0.
- Latency: master psel at cycle 0 → out_psel at cycle 1 → out_penable at cycle 2. Earliest master pready is cycle 2; each downstream wait state adds 1 cycle.
- Mandatory IDLE bubble after every completion. A master's psel still high in its own completion cycle is never re-sampled as a new request.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1...
- Requester dropping psel after grant (protocol violation): the downstream transfer still completes from the latched registers. The completion pulse is still driven to that master and is ignored.
- Reset asserted mid-transfer: immediate return to IDLE. out_psel and out_penable drop asynchronously, no pready is issued, and the downstream transfer is abandoned.
- out_* registers hold their last values in IDLE; only out_psel and out_penable are cleared.

Optional Feature:
PSRAM_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with out_pready = 0.
  - When it reaches TIMEOUT-1 with out_pready still 0, complete to the granted master with pready = 1, pslverr = 1, prdata = 32'h0.
  - Clear out_psel/out_penable and go to IDLE; last_grant updates as for a normal completion.
  - out_pready arriving in that same cycle takes priority: normal completion.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- in0 read of 0x80000010, slave ready immediately with prdata 0x12345678 → out_psel at cycle 1, out_penable at cycle 2; in0_pready = 1 with prdata 0x12345678 at cycle 2; in1 outputs all 0.
- in1 write 0x80000004, pwdata 0xA5A5A5A5, pstrb 4'b0110 → out_pwrite = 1, out_pstrb = 0110, out_pwdata = 0xA5A5A5A5 stable through SETUP and ACCESS.
- in0 and in1 request simultaneously from reset, both reissue after completion, 4 transfers → grant order 0,1,0,1, with one IDLE cycle between transfers.
- Slave inserts 5 wait states with pslverr = 1 → master pready asserted exactly once, at cycle 7, with pslverr = 1.
- PSRAM_ARB_TIMEOUT_EN, TIMEOUT = 8, slave never ready → pready = 1, pslverr = 1, prdata = 0 after 8 ACCESS cycles, then IDLE; next request is serviced normally.
- Reset pulsed during ACCESS → out_psel/out_penable go to 0 without waiting for clk, no pready; after release, in0 wins a simultaneous request.
